// File: rtl/fact_arbiter.sv
// fact_arbiter: round-robin arbiter sharing one factorial engine between two 4-phase requesters.
// Optional WAIT-state timeout is compiled in when FACT_ARB_TIMEOUT_EN is defined.
module fact_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  in0,
  input  logic [3:0]  in1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] res0,
  output logic [31:0] res1,
  output logic        eng_go,
  output logic [3:0]  eng_in,
  input  logic        eng_done,
  input  logic        eng_error,
  input  logic [31:0] eng_result,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t      state_q;
  logic [1:0]  armed_q, armed_d;
  logic [1:0]  pending;
  logic [1:0]  ack_q, err_q;
  logic [31:0] res_q [2];
  logic [3:0]  eng_in_q;
  logic        owner_q, last_q, busy_q, go_q, seen_low_q;
  logic        grant_idx, eng_flag, done_hit, complete, cmp_err;
  logic [31:0] cmp_res;

  assign eng_flag = eng_done | eng_error;
  // A completion flag only counts once it has been seen low in this WAIT,
  // so flags still high from the previous operation are ignored.
  assign done_hit = eng_flag & seen_low_q;
  assign pending  = armed_q & {req1, req0};

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign complete    = done_hit | timeout_hit;
  assign cmp_err     = done_hit ? eng_error : 1'b1;
  assign cmp_res     = !done_hit ? '1 : (eng_error ? '0 : eng_result);
`else
  assign complete    = done_hit;
  assign cmp_err     = eng_error;
  assign cmp_res     = eng_error ? '0 : eng_result;
`endif

  always_comb begin
    grant_idx = pending[1];
    if (&pending) grant_idx = ~last_q;
    // A low request re-arms; the ack edge disarms the owner until it drops req.
    armed_d = armed_q | ~{req1, req0};
    if (state_q == WAIT && complete) armed_d[owner_q] = 1'b0;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      armed_q    <= 2'b11;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      res_q[0]   <= '0;
      res_q[1]   <= '0;
      eng_in_q   <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      seen_low_q <= 1'b0;
`ifdef FACT_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      armed_q <= armed_d;
      case (state_q)
        IDLE: begin
          if (|pending) begin
            owner_q    <= grant_idx;
            eng_in_q   <= grant_idx ? in1 : in0;
            busy_q     <= 1'b1;
            go_q       <= 1'b1;
            seen_low_q <= 1'b0;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          go_q    <= 1'b0;
          state_q <= WAIT;
`ifdef FACT_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (complete) begin
            err_q[owner_q] <= cmp_err;
            res_q[owner_q] <= cmp_res;
            ack_q[owner_q] <= 1'b1;
            state_q        <= RESP;
          end else begin
            if (!eng_flag) seen_low_q <= 1'b1;
`ifdef FACT_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
        RESP: begin
          ack_q   <= 2'b00;
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign res0   = res_q[0];
  assign res1   = res_q[1];
  assign eng_go = go_q;
  assign eng_in = eng_in_q;
  assign busy   = busy_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Directed bench for fact_arbiter with a behavioural factorial engine that leaves
// its completion flags high between operations.
module tb_fact_arbiter;

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [3:0]  in0, in1;
  logic        ack0, ack1, err0, err1, eng_go, busy, owner;
  logic [31:0] res0, res1;
  logic [3:0]  eng_in;
  logic        eng_done, eng_error;
  logic [31:0] eng_result;

  int n_checks = 0;
  int n_fail   = 0;

  bit eng_err_mode = 1'b0;
  bit eng_stuck    = 1'b0;
  bit eng_release  = 1'b0;
  int eng_drop, eng_cnt;

  always #5 clk = ~clk;

  fact_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .res0(res0), .res1(res1),
    .eng_go(eng_go), .eng_in(eng_in), .eng_done(eng_done), .eng_error(eng_error),
    .eng_result(eng_result), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Engine: flags stay high until two cycles after the next go, then result after 3 more.
  initial begin
    eng_done = 1'b0; eng_error = 1'b0; eng_result = '0; eng_drop = 0; eng_cnt = 0;
    forever begin
      @(negedge clk);
      if (eng_go) eng_drop = 2;
      else if (eng_drop > 0) begin
        eng_drop--;
        if (eng_drop == 0) begin eng_done = 1'b0; eng_error = 1'b0; eng_cnt = 3; end
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_stuck) begin
          eng_done   = !eng_err_mode;
          eng_error  = eng_err_mode;
          eng_result = eng_err_mode ? 32'hDEADBEEF : fact(eng_in);
        end
      end else if (eng_release) begin
        eng_release = 1'b0;
        eng_done    = 1'b1;
        eng_result  = fact(eng_in);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;
    tick(2);
    rst = 1'b1;
  endtask

  // Waits (bounded) for the requested ack; cyc = -1 on timeout.
  task automatic wait_ack(input bit which, output int cyc, output int gos);
    cyc = -1; gos = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (eng_go) gos++;
      if ((which ? ack1 : ack0) === 1'b1) begin cyc = i; return; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({ack0, ack1, err0, err1, eng_go, busy, owner} !== 7'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000", {ack0, ack1, err0, err1, eng_go, busy, owner}); end
    n_checks++; if (res0 !== 32'h0 || res1 !== 32'h0) begin n_fail++;
      $display("FAIL reset_res: got %h/%h required 0/0", res0, res1); end
    n_checks++; if (eng_in !== 4'h0) begin n_fail++; $display("FAIL reset_eng_in: got %h required 0", eng_in); end
  endtask

  task automatic test_single();
    int cyc, gos;
    in0 = 4'd5; req0 = 1'b1;
    tick(1);
    n_checks++; if ({eng_go, busy, owner, eng_in} !== {3'b110, 4'd5}) begin n_fail++;
      $display("FAIL single_launch: got go/busy/owner/in %b%b%b/%h required 110/5", eng_go, busy, owner, eng_in); end
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 6 || gos !== 0) begin n_fail++;
      $display("FAIL single_latency: got cyc %0d gos %0d required 6 0", cyc, gos); end
    n_checks++; if (res0 !== 32'h00000078 || err0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++;
      $display("FAIL single_result: got res0 %h err0 %b ack1 %b required 00000078 0 0", res0, err0, ack1); end
    tick(1);
    n_checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL single_pulse: got ack0 %b busy %b required 0 0", ack0, busy); end
    req0 = 1'b0;
    tick(1);
  endtask

  task automatic test_both();
    int cyc, gos;
    do_reset();
    in0 = 4'd3; in1 = 4'd12; req0 = 1'b1; req1 = 1'b1;
    tick(1);
    n_checks++; if (owner !== 1'b0 || eng_go !== 1'b1 || eng_in !== 4'd3) begin n_fail++;
      $display("FAIL both_first: got owner %b go %b in %h required 0 1 3", owner, eng_go, eng_in); end
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 6 || res0 !== 32'd6 || ack1 !== 1'b0) begin n_fail++;
      $display("FAIL both_res0: got cyc %0d res0 %h ack1 %b required 6 00000006 0", cyc, res0, ack1); end
    tick(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_gap: got busy %b required 0", busy); end
    tick(1);
    n_checks++; if (owner !== 1'b1 || eng_go !== 1'b1 || eng_in !== 4'd12) begin n_fail++;
      $display("FAIL both_second: got owner %b go %b in %h required 1 1 c", owner, eng_go, eng_in); end
    wait_ack(1'b1, cyc, gos);
    n_checks++; if (cyc !== 6 || res1 !== 32'h1C8CFC00 || res0 !== 32'd6) begin n_fail++;
      $display("FAIL both_res1: got cyc %0d res1 %h res0 %h required 6 1c8cfc00 00000006", cyc, res1, res0); end
  endtask

  task automatic test_rearm();
    int cyc, gos;
    bit stayed_idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (busy !== 1'b0) stayed_idle = 1'b0;
    end
    n_checks++; if (stayed_idle !== 1'b1) begin n_fail++;
      $display("FAIL rearm_held: got a grant while req held high, required none"); end
    req0 = 1'b0;
    tick(1);
    in0 = 4'd4; req0 = 1'b1;
    tick(1);
    n_checks++; if (owner !== 1'b0 || eng_go !== 1'b1 || eng_in !== 4'd4) begin n_fail++;
      $display("FAIL rearm_grant: got owner %b go %b in %h required 0 1 4", owner, eng_go, eng_in); end
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 6 || res0 !== 32'h18) begin n_fail++;
      $display("FAIL rearm_res: got cyc %0d res0 %h required 6 00000018", cyc, res0); end
    req0 = 1'b0; req1 = 1'b0;
    tick(2);
  endtask

  task automatic test_round_robin();
    int cyc, gos;
    in0 = 4'd2; in1 = 4'd7; req0 = 1'b1; req1 = 1'b1;
    tick(1);
    n_checks++; if (owner !== 1'b1 || eng_in !== 4'd7) begin n_fail++;
      $display("FAIL rr_first: got owner %b in %h required 1 7", owner, eng_in); end
    wait_ack(1'b1, cyc, gos);
    n_checks++; if (cyc !== 6 || res1 !== 32'h13B0) begin n_fail++;
      $display("FAIL rr_res1: got cyc %0d res1 %h required 6 000013b0", cyc, res1); end
    tick(2);
    n_checks++; if (owner !== 1'b0 || eng_go !== 1'b1 || eng_in !== 4'd2) begin n_fail++;
      $display("FAIL rr_second: got owner %b go %b in %h required 0 1 2", owner, eng_go, eng_in); end
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 6 || res0 !== 32'd2) begin n_fail++;
      $display("FAIL rr_res0: got cyc %0d res0 %h required 6 00000002", cyc, res0); end
    req0 = 1'b0; req1 = 1'b0;
    tick(2);
  endtask

  task automatic test_error();
    int cyc, gos;
    eng_err_mode = 1'b1;
    in1 = 4'd13; req1 = 1'b1;
    tick(1);
    n_checks++; if (owner !== 1'b1 || eng_in !== 4'd13) begin n_fail++;
      $display("FAIL err_grant: got owner %b in %h required 1 d", owner, eng_in); end
    wait_ack(1'b1, cyc, gos);
    n_checks++; if (cyc !== 6 || err1 !== 1'b1 || res1 !== 32'h0) begin n_fail++;
      $display("FAIL err_res1: got cyc %0d err1 %b res1 %h required 6 1 00000000", cyc, err1, res1); end
    n_checks++; if (res0 !== 32'd2 || err0 !== 1'b0 || ack0 !== 1'b0) begin n_fail++;
      $display("FAIL err_other: got res0 %h err0 %b ack0 %b required 00000002 0 0", res0, err0, ack0); end
    req1 = 1'b0; eng_err_mode = 1'b0;
    tick(2);
  endtask

  task automatic test_req_drop();
    int cyc, gos;
    in0 = 4'd6; req0 = 1'b1;
    tick(1);
    req0 = 1'b0; in0 = 4'd9;
    tick(2);
    n_checks++; if (eng_in !== 4'd6 || busy !== 1'b1) begin n_fail++;
      $display("FAIL drop_hold: got in %h busy %b required 6 1", eng_in, busy); end
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 4 || res0 !== 32'h2D0 || err0 !== 1'b0) begin n_fail++;
      $display("FAIL drop_res0: got cyc %0d res0 %h err0 %b required 4 000002d0 0", cyc, res0, err0); end
    n_checks++; if (err1 !== 1'b1 || res1 !== 32'h0) begin n_fail++;
      $display("FAIL drop_other: got err1 %b res1 %h required 1 00000000", err1, res1); end
    tick(2);
  endtask

  task automatic test_mid_reset();
    bit quiet = 1'b1;
    in1 = 4'd3; req1 = 1'b1;
    tick(3);
    rst = 1'b0; req1 = 1'b0;
    tick(1);
    n_checks++; if ({busy, ack0, ack1, eng_go, err0, err1} !== 6'b0 || res0 !== 32'h0 || res1 !== 32'h0 || eng_in !== 4'h0) begin
      n_fail++; $display("FAIL midrst_state: got ctl %b res %h/%h in %h required 000000 0/0 0",
        {busy, ack0, ack1, eng_go, err0, err1}, res0, res1, eng_in); end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++;
      $display("FAIL midrst_noack: got ack/busy activity after reset, required none"); end
  endtask

  task automatic test_stuck();
    int cyc, gos;
    eng_stuck = 1'b1;
    in0 = 4'd1; req0 = 1'b1;
    tick(1);
`ifdef FACT_ARB_TIMEOUT_EN
    wait_ack(1'b0, cyc, gos);
    n_checks++; if (cyc !== 9 || err0 !== 1'b1 || res0 !== 32'hFFFFFFFF) begin n_fail++;
      $display("FAIL timeout: got cyc %0d err0 %b res0 %h required 9 1 ffffffff", cyc, err0, res0); end
    eng_stuck = 1'b0;
`else
    begin
      bit waiting = 1'b1;
      for (int i = 0; i < 30; i++) begin
        tick(1);
        if (ack0 !== 1'b0 || busy !== 1'b1) waiting = 1'b0;
      end
      n_checks++; if (waiting !== 1'b1) begin n_fail++;
        $display("FAIL stuck_wait: got early ack or idle, required WAIT to persist"); end
      eng_stuck = 1'b0; eng_release = 1'b1;
      wait_ack(1'b0, cyc, gos);
      n_checks++; if (cyc < 0 || res0 !== 32'd1 || err0 !== 1'b0) begin n_fail++;
        $display("FAIL stuck_release: got cyc %0d res0 %h err0 %b required ack 00000001 0", cyc, res0, err0); end
    end
`endif
    req0 = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_rearm();
    test_round_robin();
    test_error();
    test_req_drop();
    test_mid_reset();
    test_stuck();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fact_arbiter.md
FACT_ARBITER -- requirements
Module: fact_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1024, WAIT-state cycle limit; used only when FACT_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1.
REQ-005 in0 / in1  input  4 each  factorial operand from requester 0 / 1.
REQ-006 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 err0 / err1  output  1 each  error status of requester's last transaction.
REQ-008 res0 / res1  output  32 each  result of requester's last transaction.
REQ-009 eng_go  output  1  start pulse to the shared factorial engine.
REQ-010 eng_in  output  4  operand to the engine.
REQ-011 eng_done / eng_error  input  1 each  engine completion / error flags.
REQ-012 eng_result  input  32  engine result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 owner  output  1  index of the granted requester; valid while busy.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT and RESP.
REQ-016 IDLE: if any armed request is present, SHALL grant, latch the operand into eng_in and go to LAUNCH; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requesters armed and requesting, grant the requester that was not served last; after reset, requester 0 has priority.
REQ-018 Requester N SHALL be armed when reqN is sampled low; it is disarmed on ackN; an unarmed high reqN SHALL be ignored (4-phase handshake).
REQ-019 LAUNCH: eng_go SHALL be high for exactly this one cycle, with eng_in stable; next state is WAIT.
REQ-020 eng_in SHALL hold the latched operand from LAUNCH through RESP, independent of inN changes.
REQ-021 WAIT: a seen_low flag SHALL set when (eng_done|eng_error) is low; completion is (eng_done|eng_error) high with seen_low already set; stale flags left over from a previous operation are thereby ignored.
REQ-022 On completion, the block SHALL capture eng_error into the owner's err and capture the owner's res as 0 if eng_error, else eng_result; next state is RESP.
REQ-023 RESP: the owner's ack SHALL be high for one cycle; next state is IDLE; the last-served pointer updates to owner.
REQ-024 resN/errN SHALL hold their values until requester N's next completion; the other requester's outputs are never disturbed.
REQ-025 Latency: a request accepted in IDLE at cycle t gives eng_go at t+1; engine completion sampled at cycle d gives ackN at d+1.
REQ-026 A reqN drop after grant SHALL NOT abort the transaction; the ack is still issued.
REQ-027 Simultaneous new requests arriving during a transaction SHALL wait; no request is lost while it is held.

Reset
REQ-028 rst low at a clock edge SHALL force: state IDLE; ack0/1, err0/1, eng_go, busy, owner = 0; res0/1 = 0; eng_in = 0; both requesters armed; pointer favours requester 0; seen_low = 0; timeout counter = 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no ack issued.

Configuration
REQ-030 Macro FACT_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; after TIMEOUT cycles without completion, force completion with err=1 and res=32'hFFFFFFFF, then go to RESP.
REQ-031 Macro FACT_ARB_TIMEOUT_EN undefined: no counter; WAIT SHALL persist until engine completion.

Verification
REQ-032 req0=1, in0=5; engine completes -> single eng_go pulse with eng_in=5; ack0 pulse; res0=32'h00000078, err0=0; ack1 stays 0.
REQ-033 req0 and req1 high in the same cycle after reset (in0=3, in1=12) -> requester 0 served first (res0=6); then requester 1 (res1=32'h1C8CFC00); owner goes 0 then 1.
REQ-034 req1=1, in1=13 with engine error -> ack1 pulse, err1=1, res1=0; res0/err0 unchanged.
REQ-035 req0 held high after ack0 -> no second grant until req0 is sampled low, then high again.
REQ-036 rst low during WAIT -> next cycle: IDLE, busy=0, all acks 0, res=0; with FACT_ARB_TIMEOUT_EN and TIMEOUT=8, a stuck engine -> ack after 8 WAIT cycles, err=1, res=32'hFFFFFFFF.
